// File: rtl/ir_queue.sv
// -----------------------------------------------------------------------------
// ir_queue
//
// Instruction register with an integrated prefetch queue. The fetch side pushes
// instructions into a DEPTH-entry circular buffer. The controller pulses ld to
// move the oldest queued instruction into the registered ir_out. If the queue
// is empty when ld is pulsed, a NOP bubble is loaded instead. A flush clears
// the queue and the IR together, so a branch or jump starts from a clean state.
//
// Ports
//   clk        in   rising-edge clock
//   RST        in   asynchronous active-low reset
//   in_valid   in   fetch side presents an instruction
//   in_data    in   fetched instruction (IW bits)
//   in_ready   out  queue can accept (count != DEPTH); independent of ld
//   ld         in   load the next instruction into ir_out
//   flush      in   drop queued instructions and the current IR (highest priority)
//   ir_out     out  current instruction (registered)
//   immediate  out  ir_out[IMM_W-1:0]
//   ir_valid   out  ir_out holds a real instruction rather than a bubble
//   count      out  number of queued entries, excluding ir_out
// -----------------------------------------------------------------------------
module ir_queue #(
  parameter int              IW    = 8,
  parameter int              IMM_W = 4,
  parameter int              DEPTH = 4,
  parameter logic [IW-1:0]   NOP   = '0
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         in_valid,
  input  logic [IW-1:0]                in_data,
  output logic                         in_ready,
  input  logic                         ld,
  input  logic                         flush,
  output logic [IW-1:0]                ir_out,
  output logic [IMM_W-1:0]             immediate,
  output logic                         ir_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  // in_ready depends only on registered state, so there is no
  // combinational path from ld to the fetch side.
  assign in_ready  = (count != FULL);
  assign immediate = ir_out[IMM_W-1:0];

  // A flush swallows any same-cycle push or load. A load on an empty queue is
  // a bubble, not a pop. A same-cycle push is never bypassed into ir_out.
  assign push = in_valid && in_ready && !flush;
  assign pop  = ld && !flush && (count != '0);

  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  // NOTE: queue storage has no reset. Its contents are don't-care until
  // written, and count guarantees no unwritten entry is ever read.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  // Pointers are PW bits and DEPTH is a power of two, so they wrap naturally.
  // count alone distinguishes full from empty.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, whatever the statement order.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ir_out   <= NOP;
      ir_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ir_out   <= NOP;
      ir_valid <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (ld) begin
        if (pop) begin
          ir_out   <= mem[rd_ptr];
          ir_valid <= 1'b1;
          rd_ptr   <= rd_ptr + PW'(1);
        end else begin
          ir_out   <= NOP;
          ir_valid <= 1'b0;
        end
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// -----------------------------------------------------------------------------
// tb_ir_queue
//
// Directed bench for ir_queue. It keeps a scoreboard queue of instructions
// that the queue should accept, in push order. Each load pops the expected
// instruction from the front, or expects a NOP bubble when the scoreboard is
// empty. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_ir_queue;

  localparam int            IW    = 8;
  localparam int            IMM_W = 4;
  localparam int            DEPTH = 4;
  localparam logic [IW-1:0] NOP   = 8'h00;
  localparam int            CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             RST;
  logic             in_valid;
  logic [IW-1:0]    in_data;
  logic             in_ready;
  logic             ld;
  logic             flush;
  logic [IW-1:0]    ir_out;
  logic [IMM_W-1:0] immediate;
  logic             ir_valid;
  logic [CW-1:0]    count;

  ir_queue #(.IW(IW), .IMM_W(IMM_W), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk       (clk),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ld        (ld),
    .flush     (flush),
    .ir_out    (ir_out),
    .immediate (immediate),
    .ir_valid  (ir_valid),
    .count     (count)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [IW-1:0] sb[$];
  logic [IW-1:0] exp_ir;
  logic          exp_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of stimulus, updates the scoreboard model, clocks the DUT
  // and compares every output.
  task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l,
                       input logic f, input string tag);
    logic exp_ready;
    in_valid = v;
    in_data  = d;
    ld       = l;
    flush    = f;
    exp_ready = (sb.size() != DEPTH);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    if (f) begin
      sb.delete();
      exp_ir    = NOP;
      exp_valid = 1'b0;
    end else begin
      if (l) begin
        if (sb.size() > 0) begin
          exp_ir    = sb.pop_front();
          exp_valid = 1'b1;
        end else begin
          exp_ir    = NOP;
          exp_valid = 1'b0;
        end
      end
      if (v && exp_ready) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    check({tag, ".ir_out"},    32'(ir_out),    32'(exp_ir));
    check({tag, ".immediate"}, 32'(immediate), 32'(exp_ir[IMM_W-1:0]));
    check({tag, ".ir_valid"},  32'(ir_valid),  32'(exp_valid));
    check({tag, ".count"},     32'(count),     32'(sb.size()));
  endtask

  initial begin
    RST = 1'b0; in_valid = 1'b0; in_data = '0; ld = 1'b0; flush = 1'b0;
    exp_ir = NOP; exp_valid = 1'b0;
    #12;
    check("reset.ir_out",   32'(ir_out),   32'(NOP));
    check("reset.ir_valid", 32'(ir_valid), 32'(0));
    check("reset.count",    32'(count),    32'(0));
    RST = 1'b1;
    @(posedge clk); #1;
    check("reset.in_ready", 32'(in_ready), 32'(1));

    // 1: three pushes, then three loads
    cycle(1, 8'h15, 0, 0, "s1.push0");
    cycle(1, 8'h2A, 0, 0, "s1.push1");
    cycle(1, 8'h3F, 0, 0, "s1.push2");
    cycle(0, 8'h00, 1, 0, "s1.ld0");
    check("s1.ir_15", 32'(ir_out), 32'h15);
    cycle(0, 8'h00, 1, 0, "s1.ld1");
    cycle(0, 8'h00, 1, 0, "s1.ld2");
    check("s1.imm_F", 32'(immediate), 32'hF);
    cycle(0, 8'h00, 0, 0, "s1.hold");

    // 2: fill, push blocked while full, then one load makes room
    for (int i = 1; i <= DEPTH; i++) cycle(1, 8'(i), 0, 0, "s2.fill");
    check("s2.full_ready", 32'(in_ready), 32'(0));
    cycle(1, 8'h05, 0, 0, "s2.blocked");
    cycle(1, 8'h05, 1, 0, "s2.ld_full");
    check("s2.ir_01", 32'(ir_out), 32'h01);
    cycle(1, 8'h05, 0, 0, "s2.accept05");
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 8'h00, 1, 0, "s2.drain");

    // 3: load on empty queue with simultaneous push gives a bubble
    cycle(1, 8'h7C, 1, 0, "s3.bubble");
    check("s3.bubble_valid", 32'(ir_valid), 32'(0));
    cycle(0, 8'h00, 1, 0, "s3.ld7C");
    check("s3.ir_7C", 32'(ir_out), 32'h7C);

    // 4: flush with ld and push, while IR holds 0x33 and two entries are queued
    cycle(1, 8'h33, 0, 0, "s4.push33");
    cycle(1, 8'h11, 1, 0, "s4.ld33");
    cycle(1, 8'h22, 0, 0, "s4.push22");
    check("s4.pre_count", 32'(count), 32'(2));
    cycle(1, 8'h44, 1, 1, "s4.flush");
    cycle(0, 8'h00, 1, 0, "s4.after_flush");

    // 5: stream 0x80..0x89 across pointer wrap, loading every cycle after the first push
    cycle(1, 8'h80, 0, 0, "s5.first");
    for (int i = 1; i < 10; i++) cycle(1, 8'(8'h80 + i), 1, 0, "s5.stream");
    cycle(0, 8'h00, 1, 0, "s5.last");
    check("s5.ir_89", 32'(ir_out), 32'h89);
    cycle(0, 8'h00, 1, 0, "s5.empty");

    // 6: asynchronous reset between clock edges, mid-stream
    cycle(1, 8'h91, 0, 0, "s6.push91");
    cycle(1, 8'h92, 1, 0, "s6.ld91");
    #3;
    RST = 1'b0;
    #1;
    check("s6.async_ir_out",   32'(ir_out),   32'(NOP));
    check("s6.async_ir_valid", 32'(ir_valid), 32'(0));
    check("s6.async_count",    32'(count),    32'(0));
    sb.delete();
    exp_ir = NOP; exp_valid = 1'b0;
    in_valid = 1'b0; ld = 1'b0;
    @(negedge clk);
    RST = 1'b1;
    @(posedge clk); #1;
    cycle(1, 8'h15, 0, 0, "s6.push0");
    cycle(1, 8'h2A, 0, 0, "s6.push1");
    cycle(1, 8'h3F, 0, 0, "s6.push2");
    cycle(0, 8'h00, 1, 0, "s6.ld0");
    cycle(0, 8'h00, 1, 0, "s6.ld1");
    cycle(0, 8'h00, 1, 0, "s6.ld2");
    check("s6.ir_3F", 32'(ir_out), 32'h3F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
